// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: gathers WIDTH serial bits into a word and
// hands it to a one-entry valid/ready output register with sticky error flags.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_bit,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  output logic                     misalign,
  input  logic                     clr_flags
);
  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, data_q, data_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;
  logic             vld_q, vld_d, ovr_q, ovr_d, mis_q, mis_d;
  logic             complete, pop, push, ovr_set, mis_set;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    // A start-of-frame bit restarts the count; stale bits fall out of the shift
    // register before the word can complete, so they need no explicit clear.
    eff_cnt = in_sof ? '0 : cnt_q;
    shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], in_bit} : {in_bit, sr_q[WIDTH-1:1]};
    complete = in_valid && (eff_cnt == LAST);
    if (in_valid) begin
      sr_d  = shifted;
      cnt_d = complete ? '0 : eff_cnt + CNT_W'(1);
    end

    pop     = vld_q && out_ready;
    push    = complete;
    ovr_set = push && vld_q && !pop;
    mis_set = in_valid && in_sof && (cnt_q != '0);
    if (push && (!vld_q || pop)) begin
      data_d = shifted;
      vld_d  = 1'b1;
    end else if (pop && !push) begin
      vld_d  = 1'b0;
    end

    // Set beats clear when both land in the same cycle.
    ovr_d = ovr_set || (ovr_q && !clr_flags);
    mis_d = mis_set || (mis_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      mis_q  <= mis_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;
  assign misalign  = mis_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one stimulus
// stream and are checked every cycle against a bit-list reference model.
module tb_sipo_deser;
  localparam int W = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic in_bit = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
  logic [W-1:0] m_data, l_data;
  logic m_valid, l_valid, m_ovr, l_ovr, m_mis, l_mis;
  logic [2:0] m_cnt, l_cnt;

  int n_checks = 0, n_fail = 0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready), .bit_cnt(m_cnt),
    .overrun(m_ovr), .misalign(m_mis), .clr_flags(clr_flags));

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready), .bit_cnt(l_cnt),
    .overrun(l_ovr), .misalign(l_mis), .clr_flags(clr_flags));

  always #5 clk = ~clk;

  // Reference model: the partial word is simply the list of bits received so far.
  bit       q_bits[$];
  bit       e_valid, e_ovr, e_mis;
  bit [W-1:0] e_mdata, e_ldata;

  always @(posedge clk or negedge reset_n) begin
    bit pop, push, set_o, set_m;
    bit [W-1:0] wm, wl;
    if (!reset_n) begin
      q_bits.delete();
      e_valid = 0; e_ovr = 0; e_mis = 0; e_mdata = '0; e_ldata = '0;
    end else begin
      pop = e_valid && out_ready;
      push = 0; set_o = 0; set_m = 0; wm = '0; wl = '0;
      if (in_valid) begin
        if (in_sof) begin
          if (q_bits.size() != 0) set_m = 1;
          q_bits.delete();
        end
        q_bits.push_back(in_bit);
        if (q_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm = wm + (W'(q_bits[i]) << (W - 1 - i));
            wl = wl + (W'(q_bits[i]) << i);
          end
          push = 1;
          q_bits.delete();
        end
      end
      if (push && (!e_valid || pop)) begin
        e_valid = 1; e_mdata = wm; e_ldata = wl;
      end else if (push) set_o = 1;
      else if (pop) e_valid = 0;
      e_ovr = set_o ? 1'b1 : (clr_flags ? 1'b0 : e_ovr);
      e_mis = set_m ? 1'b1 : (clr_flags ? 1'b0 : e_mis);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("msb_valid", 32'(m_valid), 32'(e_valid));
      check("lsb_valid", 32'(l_valid), 32'(e_valid));
      check("msb_cnt", 32'(m_cnt), 32'(q_bits.size()));
      check("lsb_cnt", 32'(l_cnt), 32'(q_bits.size()));
      check("msb_ovr", 32'(m_ovr), 32'(e_ovr));
      check("lsb_ovr", 32'(l_ovr), 32'(e_ovr));
      check("msb_mis", 32'(m_mis), 32'(e_mis));
      check("lsb_mis", 32'(l_mis), 32'(e_mis));
      if (e_valid) begin
        check("msb_data", 32'(m_data), 32'(e_mdata));
        check("lsb_data", 32'(l_data), 32'(e_ldata));
      end
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic drive(input logic v, input logic b, input logic sof, input logic clr = 1'b0);
    in_valid = v; in_bit = b; in_sof = sof; clr_flags = clr;
    @(posedge clk); #2;
    in_valid = 0; in_sof = 0; clr_flags = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic sof, input bit gaps = 0);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b1, w[i], (i == W - 1) && sof);
      if (gaps) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  int pulses;

  initial begin
    #1;
    check("rst_data", 32'(m_data), 0);
    check("rst_flags", {28'd0, m_valid, m_ovr, m_mis, l_valid}, 0);
    check("rst_cnt", 32'(m_cnt), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // 1/2: A5 with SOF, both orders give A5
    out_ready = 1;
    send_word(8'hA5, 1'b1);
    check("t1_msb_data", 32'(m_data), 32'h A5);
    check("t1_lsb_data", 32'(l_data), 32'h A5);
    check("t1_valid", 32'(m_valid), 1);
    check("t1_cnt", 32'(m_cnt), 0);
    drive(0, 0, 0);
    check("t1_valid_drop", 32'(m_valid), 0);
    send_word(8'h80, 1'b0);   // stream 1,0,0,0,0,0,0,0
    check("t2_msb_data", 32'(m_data), 32'h80);
    check("t2_lsb_data", 32'(l_data), 32'h01);
    drive(0, 0, 0);

    // 3: overrun while output held
    out_ready = 0;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    check("t3_data_held", 32'(m_data), 32'h3C);
    check("t3_overrun", 32'(m_ovr), 1);
    drive(0, 0, 0, 1'b1);
    check("t3_overrun_clr", 32'(m_ovr), 0);
    out_ready = 1;
    drive(0, 0, 0);

    // 4: three back-to-back words, no loss
    pulses = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < W; i++) begin
        drive(1'b1, 1'($urandom_range(1)), 1'b0);
        if (m_valid) pulses++;
      end
    check("t4_pulses", 32'(pulses), 3);
    check("t4_overrun", 32'(m_ovr), 0);
    drive(0, 0, 0);

    // 5: gaps between bits
    send_word(8'h96, 1'b1, 1'b1);
    check("t5_gap_data", 32'(m_data), 32'h96);
    drive(0, 0, 0);

    // 6: misaligned SOF, then async reset mid-word
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("t6_misalign", 32'(m_mis), 1);
    check("t6_cnt", 32'(m_cnt), 1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'(i == 6), 1'b0);
    check("t6_word", 32'(m_data), 32'h81);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    reset_n = 0;
    #1;
    check("t6_rst_data", {m_data, l_data}, 0);
    check("t6_rst_other", {26'd0, m_valid, m_cnt, m_ovr, m_mis}, 0);
    @(posedge clk); #2 reset_n = 1;

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      out_ready = 1'($urandom_range(3) != 0);
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
            1'($urandom_range(15) == 0), 1'($urandom_range(31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
